// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI host engine and the slave-side controller:
// FSM state encoding, header field positions and op codes.
package qspi_pkg;

  // Default link word width; the engine takes its real width from a parameter.
  localparam int QSPI_DW = 16;

  // Header layout: op bit sits at DW-1, burst length starts at bit 0.
  localparam int HDR_LEN_LSB = 0;

  // Op codes carried in the header op bit.
  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  // Host engine states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_ADDR_HI = 3'd2,
    S_ADDR_LO = 3'd3,
    S_WDATA   = 3'd4,
    S_RWAIT   = 3'd5,
    S_DONE    = 3'd6
  } qspi_state_t;

endpackage

// File: rtl/qspi_frame_mux.sv
// Selects the outgoing link word for the current frame position and
// registers it onto mosi together with its one-cycle qualifier.
module qspi_frame_mux
  import qspi_pkg::*;
#(
  parameter int DW = QSPI_DW
) (
  input  logic          clk_slow,
  input  logic          rst_slow,
  input  qspi_state_t   state,
  input  logic          issue,
  input  logic [DW-1:0] hdr_word,
  input  logic [DW-1:0] addr_hi,
  input  logic [DW-1:0] addr_lo,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] mosi,
  output logic          mosi_valid
);

  logic [DW-1:0] word_sel;

  // Pick the word belonging to the frame slot the FSM is currently in.
  always_comb begin
    word_sel = '0;
    case (state)
      S_HDR:     word_sel = hdr_word;
      S_ADDR_HI: word_sel = addr_hi;
      S_ADDR_LO: word_sel = addr_lo;
      S_WDATA:   word_sel = wr_data;
      default:   word_sel = '0;
    endcase
  end

  // Register the word on issue; mosi holds its last value between words.
  always_ff @(posedge clk_slow or posedge rst_slow) begin
    if (rst_slow) begin
      mosi       <= '0;
      mosi_valid <= 1'b0;
    end else begin
      mosi_valid <= issue;
      if (issue) begin
        mosi <= word_sel;
      end
    end
  end

endmodule

// File: rtl/qspi_host.sv
// Host-side QSPI word transaction engine. Frames one read or write request
// into header / address / data link words and collects returned read words.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | ready for a request; latches op, address and length on accept
// S_HDR     | issue header word {op, 0.., len}
// S_ADDR_HI | issue upper address word (zero-extended)
// S_ADDR_LO | issue lower address word
// S_WDATA   | pass len+1 payload words from wr_data to the link
// S_RWAIT   | collect len+1 miso words, abort on read timeout
// S_DONE    | pulse done, return to idle
module qspi_host
  import qspi_pkg::*;
#(
  parameter int DW      = QSPI_DW,
  parameter int CTRL_AW = 22,
  parameter int LEN_W   = 9,
  parameter int TO_W    = 12
) (
  input  logic               clk_slow,
  input  logic               rst_slow,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [CTRL_AW-1:0] req_addr,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [DW-1:0]      wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic               timeout,
  output logic [DW-1:0]      mosi,
  output logic               mosi_valid,
  input  logic               link_full,
  input  logic [DW-1:0]      miso,
  input  logic               miso_valid
);

  // Timeout fires on the cycle the counter would reach all-ones.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  qspi_state_t        state;
  logic               op_q;
  logic [CTRL_AW-1:0] addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [TO_W-1:0]    tcnt;

  logic               issue;
  logic               frame_slot;
  logic [DW-1:0]      hdr_word;
  logic [DW-1:0]      addr_hi;
  logic [DW-1:0]      addr_lo;

  assign req_ready  = (state == S_IDLE);
  assign wr_ready   = (state == S_WDATA) && !link_full;
  assign frame_slot = (state == S_HDR) || (state == S_ADDR_HI) || (state == S_ADDR_LO);

  // link_full only gates whether a word goes out this cycle.
  assign issue = !link_full && (frame_slot || ((state == S_WDATA) && wr_valid));

  // Build the header and address words from the latched request.
  always_comb begin
    hdr_word                          = '0;
    hdr_word[DW-1]                    = op_q;
    hdr_word[HDR_LEN_LSB +: LEN_W]    = len_q;
  end

  assign addr_hi = DW'(addr_q >> DW);
  assign addr_lo = addr_q[DW-1:0];

  // Transaction sequencing, word counting, read capture and timeout.
  always_ff @(posedge clk_slow or posedge rst_slow) begin
    if (rst_slow) begin
      state    <= S_IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_write ? OP_WR : OP_RD;
            addr_q <= req_addr;
            len_q  <= req_len;
            cnt    <= '0;
            tcnt   <= '0;
            state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (!link_full) state <= S_ADDR_HI;
        end
        S_ADDR_HI: begin
          if (!link_full) state <= S_ADDR_LO;
        end
        S_ADDR_LO: begin
          if (!link_full) state <= (op_q == OP_RD) ? S_RWAIT : S_WDATA;
        end
        S_WDATA: begin
          // Compare before incrementing so len = all-ones never wraps early.
          if (wr_valid && !link_full) begin
            if (cnt == len_q) state <= S_DONE;
            else              cnt   <= cnt + 1'b1;
          end
        end
        S_RWAIT: begin
          if (miso_valid) begin
            rd_data  <= miso;
            rd_valid <= 1'b1;
            tcnt     <= '0;
            if (cnt == len_q) state <= S_DONE;
            else              cnt   <= cnt + 1'b1;
          end else if (tcnt == TO_LAST) begin
            timeout <= 1'b1;
            cnt     <= '0;
            tcnt    <= '0;
            state   <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  qspi_frame_mux #(.DW(DW)) u_frame_mux (
    .clk_slow   (clk_slow),
    .rst_slow   (rst_slow),
    .state      (state),
    .issue      (issue),
    .hdr_word   (hdr_word),
    .addr_hi    (addr_hi),
    .addr_lo    (addr_lo),
    .wr_data    (wr_data),
    .mosi       (mosi),
    .mosi_valid (mosi_valid)
  );

endmodule

// File: tb/tb_qspi_host.sv
// Directed bench for qspi_host: framing, read capture, link stalls,
// read timeout, mid-transaction reset and a maximum-length burst.
module tb_qspi_host;

  logic        clk_slow = 1'b0;
  logic        rst_slow;
  logic        req_valid, req_ready, req_write;
  logic [21:0] req_addr;
  logic [8:0]  req_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, done, timeout;
  logic [15:0] mosi;
  logic        mosi_valid, link_full;
  logic [15:0] miso;
  logic        miso_valid;

  qspi_host #(.DW(16), .CTRL_AW(22), .LEN_W(9), .TO_W(4)) dut (
    .clk_slow   (clk_slow),
    .rst_slow   (rst_slow),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .timeout    (timeout),
    .mosi       (mosi),
    .mosi_valid (mosi_valid),
    .link_full  (link_full),
    .miso       (miso),
    .miso_valid (miso_valid)
  );

  always #5 clk_slow = ~clk_slow;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  int          acc_c, done_c, to_c, n_done, n_to, wi;
  logic [15:0] wq[$];
  logic [15:0] mis_q[$];
  logic [15:0] mq[$];
  int          mc[$];
  logic [15:0] rq[$];
  int          rc[$];
  int          mis_c[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_slow);
    @(negedge clk_slow);
    cyc_n++;
    if (mosi_valid) begin mq.push_back(mosi); mc.push_back(cyc_n); end
    if (rd_valid)   begin rq.push_back(rd_data); rc.push_back(cyc_n); end
    if (done)       begin n_done++; done_c = cyc_n; end
    if (timeout)    begin n_to++; to_c = cyc_n; end
  endtask

  // Run one request. Stray miso words are offered whenever the engine is
  // not waiting for read data; they must be ignored.
  task automatic do_txn(input bit wr, input logic [21:0] addr, input logic [8:0] len,
                        input int lf_at, input int lf_n, input int stop_wi, input int budget);
    bit acc;
    bit gap;
    mq.delete(); mc.delete(); rq.delete(); rc.delete(); mis_c.delete();
    n_done = 0; n_to = 0; wi = 0; done_c = -1; to_c = -1; acc = 0; gap = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    wr_valid  = wr && (wq.size() > 0);
    wr_data   = wr_valid ? wq[0] : 16'h0;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      acc = req_ready;
      cyc();
    end
    acc_c = cyc_n;
    req_valid = 1'b0;
    check_eq("req_accept", {31'd0, acc}, 32'd1);
    for (int k = 0; k < budget; k++) begin
      int off;
      bit fire;
      if (n_done > 0 || n_to > 0) break;
      if (stop_wi >= 0 && wi == stop_wi) break;
      off = cyc_n - acc_c;
      link_full  = (off >= lf_at) && (off < lf_at + lf_n);
      miso_valid = 1'b0;
      miso       = 16'hDEAD;
      if (!wr && mq.size() >= 3) begin
        if (mis_q.size() > 0 && !gap) begin
          miso_valid = 1'b1;
          miso       = mis_q.pop_front();
          mis_c.push_back(cyc_n + 1);
        end
        gap = miso_valid;
      end else begin
        miso_valid = 1'b1;
      end
      #1;
      fire = wr_valid && wr_ready;
      cyc();
      if (fire) wi++;
      wr_valid = wr && (wi < wq.size());
      wr_data  = wr_valid ? wq[wi] : 16'h0;
    end
    link_full  = 1'b0;
    miso_valid = 1'b0;
    wr_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_w[$];
    int          base;
    rst_slow = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 0; link_full = 0; miso = '0; miso_valid = 0;
    @(negedge clk_slow);
    @(negedge clk_slow);
    check_eq("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check_eq("rst_wr_ready",   {31'd0, wr_ready},   32'd0);
    check_eq("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    check_eq("rst_done",       {31'd0, done},       32'd0);
    check_eq("rst_timeout",    {31'd0, timeout},    32'd0);
    check_eq("rst_mosi_valid", {31'd0, mosi_valid}, 32'd0);
    check_eq("rst_mosi",       {16'd0, mosi},       32'd0);
    check_eq("rst_rd_data",    {16'd0, rd_data},    32'd0);
    rst_slow = 1'b0;
    idle(2);

    // Write, addr 0x2A_BCDE, len 2
    wq = '{16'h1111, 16'h2222, 16'h3333};
    do_txn(1'b1, 22'h2A_BCDE, 9'd2, 0, 0, -1, 40);
    idle(3);
    exp_w = '{16'h8002, 16'h002A, 16'hBCDE, 16'h1111, 16'h2222, 16'h3333};
    check_eq("wr_nwords", mq.size(), 6);
    for (int i = 0; i < 6 && i < mq.size(); i++) begin
      check_eq($sformatf("wr_word%0d", i), {16'd0, mq[i]}, {16'd0, exp_w[i]});
      check_eq($sformatf("wr_cyc%0d", i), mc[i], acc_c + 1 + i);
    end
    check_eq("wr_done_cyc", done_c, acc_c + 7);
    check_eq("wr_done_cnt", n_done, 1);
    check_eq("wr_stray_rd", rq.size(), 0);

    // Read, addr 0x00_0010, len 1
    mis_q = '{16'hA5A5, 16'h5A5A};
    do_txn(1'b0, 22'h00_0010, 9'd1, 0, 0, -1, 40);
    idle(3);
    exp_w = '{16'h0001, 16'h0000, 16'h0010};
    check_eq("rd_nwords", mq.size(), 3);
    for (int i = 0; i < 3 && i < mq.size(); i++)
      check_eq($sformatf("rd_word%0d", i), {16'd0, mq[i]}, {16'd0, exp_w[i]});
    check_eq("rd_nvalid", rq.size(), 2);
    if (rq.size() == 2) begin
      check_eq("rd_data0", {16'd0, rq[0]}, 32'h0000A5A5);
      check_eq("rd_data1", {16'd0, rq[1]}, 32'h00005A5A);
      check_eq("rd_lat0", rc[0], mis_c[0]);
      check_eq("rd_lat1", rc[1], mis_c[1]);
      check_eq("rd_done_cyc", done_c, rc[1] + 1);
    end
    check_eq("rd_done_cnt", n_done, 1);

    // link_full held 3 cycles while ADDR_HI is pending
    wq = '{16'h1111, 16'h2222, 16'h3333};
    do_txn(1'b1, 22'h2A_BCDE, 9'd2, 1, 3, -1, 40);
    idle(3);
    exp_w = '{16'h8002, 16'h002A, 16'hBCDE, 16'h1111, 16'h2222, 16'h3333};
    check_eq("lf_nwords", mq.size(), 6);
    for (int i = 0; i < 6 && i < mq.size(); i++)
      check_eq($sformatf("lf_word%0d", i), {16'd0, mq[i]}, {16'd0, exp_w[i]});
    if (mq.size() == 6) begin
      check_eq("lf_hdr_cyc",  mc[0], acc_c + 1);
      check_eq("lf_hi_cyc",   mc[1], acc_c + 5);
      check_eq("lf_last_cyc", mc[5], acc_c + 9);
    end
    check_eq("lf_done_cyc", done_c, acc_c + 10);

    // Read with no returning data: timeout after 15 cycles in RWAIT
    mis_q.delete();
    do_txn(1'b0, 22'h12_3456, 9'd3, 0, 0, -1, 60);
    check_eq("to_nwords", mq.size(), 3);
    check_eq("to_cnt", n_to, 1);
    if (mq.size() == 3) check_eq("to_cyc", to_c, mc[2] + 15);
    cyc();
    check_eq("to_req_ready", {31'd0, req_ready}, 32'd1);
    idle(3);
    check_eq("to_no_done", n_done, 0);
    check_eq("to_no_rd", rq.size(), 0);

    // Reset after two write data words
    wq = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E};
    do_txn(1'b1, 22'h01_0203, 9'd4, 0, 0, 2, 40);
    check_eq("rst_mid_words", mq.size(), 5);
    rst_slow = 1'b1;
    #1;
    check_eq("rstm_req_ready",  {31'd0, req_ready},  32'd1);
    check_eq("rstm_wr_ready",   {31'd0, wr_ready},   32'd0);
    check_eq("rstm_mosi_valid", {31'd0, mosi_valid}, 32'd0);
    check_eq("rstm_mosi",       {16'd0, mosi},       32'd0);
    check_eq("rstm_rd_data",    {16'd0, rd_data},    32'd0);
    cyc();
    rst_slow = 1'b0;
    base = mq.size();
    idle(4);
    check_eq("rstm_no_words", mq.size(), base);
    check_eq("rstm_no_done", n_done, 0);
    wq = '{16'h7777};
    do_txn(1'b1, 22'h3F_0001, 9'd0, 0, 0, -1, 40);
    idle(3);
    exp_w = '{16'h8000, 16'h003F, 16'h0001, 16'h7777};
    check_eq("post_rst_nwords", mq.size(), 4);
    for (int i = 0; i < 4 && i < mq.size(); i++)
      check_eq($sformatf("post_rst_word%0d", i), {16'd0, mq[i]}, {16'd0, exp_w[i]});
    check_eq("post_rst_done", n_done, 1);

    // Maximum burst, len 0x1FF = 512 data words
    wq.delete();
    for (int i = 0; i < 512; i++) wq.push_back(16'(i * 3 + 1));
    do_txn(1'b1, 22'h15_5AA5, 9'h1FF, 0, 0, -1, 700);
    idle(3);
    check_eq("big_nwords", mq.size(), 515);
    if (mq.size() == 515) begin
      check_eq("big_hdr", {16'd0, mq[0]}, 32'h000081FF);
      check_eq("big_hi",  {16'd0, mq[1]}, 32'h00000015);
      check_eq("big_lo",  {16'd0, mq[2]}, 32'h00005AA5);
      for (int i = 0; i < 512; i++)
        check_eq($sformatf("big_d%0d", i), {16'd0, mq[3 + i]}, {16'd0, 16'(i * 3 + 1)});
      check_eq("big_last_cyc", mc[514], acc_c + 515);
    end
    check_eq("big_done_cyc", done_c, acc_c + 516);
    check_eq("big_done_cnt", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
